traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Safety stage directly downstream of the traffic-light controller. It consumes the six lamp requests (`ns_g/y/r`, `ew_g/y/r`) and the shared `tick` pulse, and passes them to the lamp drivers with one cycle of latency. It checks every request for one-hot violations, cross-road conflicts, illegal sequences, short yellows and a stuck controller. On the first violation it latches a fault code and forces both roads to flashing red until reset.

## Interface
- `MIN_YELLOW_TICKS`, default 2: minimum ticks a road must show yellow before going red.
- `WATCHDOG_TICKS`, default 16: ticks with no change on any input lamp before a stuck fault is raised.
- `FLASH_HALF_TICKS`, default 1: ticks per on/off half-period of fail-safe red flashing.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle pulse at tick rate, the same pulse the controller uses.
- `ns_g`, `ns_y`, `ns_r` in 1 each: NS lamp requests from the controller.
- `ew_g`, `ew_y`, `ew_r` in 1 each: EW lamp requests from the controller.
- `ns_g_o`, `ns_y_o`, `ns_r_o` out 1 each: registered NS lamp drives.
- `ew_g_o`, `ew_y_o`, `ew_r_o` out 1 each: registered EW lamp drives.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: latched cause. 0 = none, 1 = not one-hot, 2 = conflict, 3 = illegal sequence, 4 = short yellow, 5 = watchdog.

## Operation
- Modes are NORMAL and FAULT. FAULT is exited only by `rst`.
- Previous-sample registers hold last cycle's inputs per road. They reset to R (red only).
- NORMAL: each output lamp is the corresponding input registered, giving 1 cycle latency.
- Checks run every cycle on the current inputs compared against the previous sample:
  - Code 1: either road's {g,y,r} is not exactly one-hot.
  - Code 2: both roads are non-red at once.
  - Code 3: a per-road transition other than G→Y, Y→R, R→G, or no change (for example G→R, Y→G, R→Y).
  - Code 4: a Y→R transition while that road's yellow tick count is below `MIN_YELLOW_TICKS`.
  - Code 5: the watchdog count reaches `WATCHDOG_TICKS`.
- Simultaneous violations: the lowest code wins.
- Yellow counter, one per road:
  - Cleared on the cycle the road enters Y.
  - Increments on every `tick` while that road's input is Y, including the tick on which it leaves.
  - Saturates at `MIN_YELLOW_TICKS`.
- Watchdog counter:
  - Cleared on any change of any of the six inputs.
  - Otherwise increments on `tick`.
  - Saturates.
- On detection, at the same posedge:
  - `fault` is set to 1 and `fault_code` is set to the winning code.
  - Outputs switch to fail-safe, so the offending pattern never reaches the outputs.
- FAULT mode:
  - All g and y outputs are 0.
  - `ns_r_o` = `ew_r_o` = the flash phase.
  - The flash phase starts at 1 and toggles after every `FLASH_HALF_TICKS` ticks.
  - Inputs are ignored and `fault_code` is frozen.
- Counter widths use `$clog2` of their saturation value plus 1.

## Timing
- Reset values:
  - Red outputs `ns_r_o` and `ew_r_o` are 1.
  - All g and y outputs are 0.
  - `fault` is 0 and `fault_code` is 0.
  - All counters are 0 and the flash phase is 1.
- Pass-through latency is 1 clock. Fault entry takes effect at the posedge that samples the violation.
- Reset mid-FAULT returns to NORMAL with all-red outputs on the next cycle.
- The first post-reset input pattern NS=G, EW=R is legal, because R→G is permitted.
- `tick` is only a count enable. Lamp changes between ticks are still checked every clock.

## Configuration
- `TLM_WATCHDOG_EN` defined: the watchdog counter and code 5 are compiled in.
- `TLM_WATCHDOG_EN` undefined:
  - No watchdog logic is built.
  - Code 5 never occurs.
  - The `WATCHDOG_TICKS` parameter is accepted but unused.

## Test plan
- Legal cycle: controller timing G5/Y2/G5/Y2, `tick` every 4 clocks, 3 full cycles → outputs equal the inputs delayed 1 clock, `fault` stays 0.
- Conflict: force `ns_g`=1 and `ew_g`=1 in the same cycle (EW reds 0) → next posedge gives `fault`=1, `fault_code`=2, all g/y outputs 0, red outputs 1.
- Skip yellow: drive NS G→R directly → `fault_code`=3; with `FLASH_HALF_TICKS`=1 the reds toggle 1,0,1 on successive ticks.
- Short yellow: hold NS yellow for 1 tick then red, `MIN_YELLOW_TICKS`=2 → `fault_code`=4. The same sequence with 2 ticks → no fault.
- Stuck and priority: freeze the inputs for 16 ticks → `fault_code`=5 (only with `TLM_WATCHDOG_EN`). Separately, inject `ns_g`=`ns_r`=1 together with `ew_g`=1 → `fault_code`=1.
- Reset mid-fault: assert `rst` for 1 cycle while in FAULT → `fault`=0, `fault_code`=0, both red outputs 1, and a legal cycle passes afterwards.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Safety stage between the traffic-light controller and the lamp drivers.
// Lamp requests pass through with one clock of latency while every cycle is
// checked for lamp-pattern and sequencing violations. The first violation
// latches a fault code and locks both roads into flashing red until rst.
//
// Optional feature: define TLM_WATCHDOG_EN to build the stuck-controller
// watchdog (fault code 5). Without it WATCHDOG_TICKS is accepted but unused.
//
// Parameters:
//   MIN_YELLOW_TICKS - minimum ticks of yellow before a road may go red
//   WATCHDOG_TICKS   - ticks without any input change before a stuck fault
//   FLASH_HALF_TICKS - ticks per on/off half-period of fail-safe flashing
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   tick                     - one-cycle tick pulse (count enable only)
//   ns_g/ns_y/ns_r           - NS lamp requests from the controller
//   ew_g/ew_y/ew_r           - EW lamp requests from the controller
//   ns_*_o, ew_*_o           - registered lamp drives
//   fault                    - latched fault flag
//   fault_code[2:0]          - latched cause: 0 none, 1 not one-hot,
//                              2 conflict, 3 illegal sequence,
//                              4 short yellow, 5 watchdog
// -----------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW_TICKS = 2,
    parameter int WATCHDOG_TICKS   = 16,
    parameter int FLASH_HALF_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_g,
    input  logic       ns_y,
    input  logic       ns_r,
    input  logic       ew_g,
    input  logic       ew_y,
    input  logic       ew_r,
    output logic       ns_g_o,
    output logic       ns_y_o,
    output logic       ns_r_o,
    output logic       ew_g_o,
    output logic       ew_y_o,
    output logic       ew_r_o,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int YW = $clog2(MIN_YELLOW_TICKS) + 1;
    localparam int FW = $clog2(FLASH_HALF_TICKS) + 1;

    localparam logic [YW-1:0] YEL_MAX    = YW'(MIN_YELLOW_TICKS);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF_TICKS - 1);

    // Lamp patterns packed as {g, y, r}
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    typedef enum logic [0:0] {
        MODE_NORMAL = 1'b0,
        MODE_FAULT  = 1'b1
    } mode_t;

    function automatic logic is_one_hot(input logic [2:0] lamp);
        return (lamp == LAMP_G) || (lamp == LAMP_Y) || (lamp == LAMP_R);
    endfunction

    // Legal per-road steps: hold, G->Y, Y->R, R->G
    function automatic logic is_legal_step(input logic [2:0] prev_l, input logic [2:0] cur_l);
        logic ok;
        case (prev_l)
            LAMP_G:  ok = (cur_l == LAMP_G) || (cur_l == LAMP_Y);
            LAMP_Y:  ok = (cur_l == LAMP_Y) || (cur_l == LAMP_R);
            LAMP_R:  ok = (cur_l == LAMP_R) || (cur_l == LAMP_G);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Yellow counter step: clear on entering Y, count ticks while Y and on
    // the cycle the road leaves Y, saturating at MIN_YELLOW_TICKS.
    function automatic logic [YW-1:0] yel_next(input logic [2:0]    prev_l,
                                               input logic [2:0]    cur_l,
                                               input logic [YW-1:0] cnt,
                                               input logic          tk);
        logic [YW-1:0] res;
        if ((cur_l == LAMP_Y) && (prev_l != LAMP_Y)) begin
            res = {YW{1'b0}};
        end else if (tk && ((cur_l == LAMP_Y) || (prev_l == LAMP_Y)) && (cnt < YEL_MAX)) begin
            res = cnt + YW'(1'b1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    mode_t         mode_r;
    logic [2:0]    ns_prev_r;
    logic [2:0]    ew_prev_r;
    logic [YW-1:0] ns_ycnt_r;
    logic [YW-1:0] ew_ycnt_r;
    logic          flash_r;
    logic [FW-1:0] flash_cnt_r;

    logic [2:0]    ns_s;
    logic [2:0]    ew_s;
    logic [YW-1:0] ns_ycnt_nxt_s;
    logic [YW-1:0] ew_ycnt_nxt_s;
    logic          bad_hot_s;
    logic          conflict_s;
    logic          bad_seq_s;
    logic          short_yel_s;
    logic          wd_hit_s;
    logic [2:0]    det_code_s;
    logic          flash_next_s;

    assign ns_s = {ns_g, ns_y, ns_r};
    assign ew_s = {ew_g, ew_y, ew_r};

`ifdef TLM_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_TICKS) + 1;
    localparam logic [WW-1:0] WD_MAX = WW'(WATCHDOG_TICKS);

    logic [WW-1:0] wd_cnt_r;
    logic          in_change_s;

    assign in_change_s = ({ns_s, ew_s} != {ns_prev_r, ew_prev_r});
    assign wd_hit_s    = (wd_cnt_r >= WD_MAX);

    // Watchdog: cleared by any input change, otherwise counts ticks (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= {WW{1'b0}};
        end else if (in_change_s) begin
            wd_cnt_r <= {WW{1'b0}};
        end else if (tick && (wd_cnt_r < WD_MAX)) begin
            wd_cnt_r <= wd_cnt_r + WW'(1'b1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    assign wd_hit_s = 1'b0;
`endif

    // Violation detection on current inputs against the previous sample
    always_comb begin
        ns_ycnt_nxt_s = yel_next(ns_prev_r, ns_s, ns_ycnt_r, tick);
        ew_ycnt_nxt_s = yel_next(ew_prev_r, ew_s, ew_ycnt_r, tick);
        bad_hot_s     = !is_one_hot(ns_s) || !is_one_hot(ew_s);
        conflict_s    = (ns_s != LAMP_R) && (ew_s != LAMP_R);
        bad_seq_s     = !is_legal_step(ns_prev_r, ns_s) || !is_legal_step(ew_prev_r, ew_s);
        // The leaving cycle's tick already counts in the *_nxt_s values
        short_yel_s   = ((ns_prev_r == LAMP_Y) && (ns_s == LAMP_R) && (ns_ycnt_nxt_s < YEL_MAX)) ||
                        ((ew_prev_r == LAMP_Y) && (ew_s == LAMP_R) && (ew_ycnt_nxt_s < YEL_MAX));
        det_code_s    = 3'd0;
        if (bad_hot_s) begin
            det_code_s = 3'd1;
        end else if (conflict_s) begin
            det_code_s = 3'd2;
        end else if (bad_seq_s) begin
            det_code_s = 3'd3;
        end else if (short_yel_s) begin
            det_code_s = 3'd4;
        end else if (wd_hit_s) begin
            det_code_s = 3'd5;
        end else begin
            det_code_s = 3'd0;
        end
    end

    // Fail-safe flash phase: toggles once every FLASH_HALF_TICKS ticks
    always_comb begin
        flash_next_s = flash_r;
        if (tick && (flash_cnt_r == FLASH_LAST)) begin
            flash_next_s = ~flash_r;
        end else begin
            flash_next_s = flash_r;
        end
    end

    // Mode FSM with registered lamp drives, fault latch and road history
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= MODE_NORMAL;
            ns_prev_r   <= LAMP_R;
            ew_prev_r   <= LAMP_R;
            ns_ycnt_r   <= {YW{1'b0}};
            ew_ycnt_r   <= {YW{1'b0}};
            flash_r     <= 1'b1;
            flash_cnt_r <= {FW{1'b0}};
            {ns_g_o, ns_y_o, ns_r_o} <= LAMP_R;
            {ew_g_o, ew_y_o, ew_r_o} <= LAMP_R;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
        end else begin
            case (mode_r)
                MODE_NORMAL: begin
                    ns_prev_r <= ns_s;
                    ew_prev_r <= ew_s;
                    ns_ycnt_r <= ns_ycnt_nxt_s;
                    ew_ycnt_r <= ew_ycnt_nxt_s;
                    if (det_code_s != 3'd0) begin
                        // Offending pattern is replaced at the same edge
                        mode_r      <= MODE_FAULT;
                        fault       <= 1'b1;
                        fault_code  <= det_code_s;
                        flash_r     <= 1'b1;
                        flash_cnt_r <= {FW{1'b0}};
                        {ns_g_o, ns_y_o, ns_r_o} <= LAMP_R;
                        {ew_g_o, ew_y_o, ew_r_o} <= LAMP_R;
                    end else begin
                        {ns_g_o, ns_y_o, ns_r_o} <= ns_s;
                        {ew_g_o, ew_y_o, ew_r_o} <= ew_s;
                    end
                end
                MODE_FAULT: begin
                    flash_r <= flash_next_s;
                    if (tick) begin
                        flash_cnt_r <= (flash_cnt_r == FLASH_LAST) ? {FW{1'b0}}
                                                                   : flash_cnt_r + FW'(1'b1);
                    end else begin
                        flash_cnt_r <= flash_cnt_r;
                    end
                    {ns_g_o, ns_y_o, ns_r_o} <= {2'b00, flash_next_s};
                    {ew_g_o, ew_y_o, ew_r_o} <= {2'b00, flash_next_s};
                end
                default: begin
                    // Unreachable encoding: fall into fail-safe
                    mode_r <= MODE_FAULT;
                    fault  <= 1'b1;
                    {ns_g_o, ns_y_o, ns_r_o} <= LAMP_R;
                    {ew_g_o, ew_y_o, ew_r_o} <= LAMP_R;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_conflict_monitor (default parameters).
// The driver applies directed vectors on the falling edge and queues the
// hand-computed output expected after the following rising edge; an
// independent monitor pops and compares one entry per cycle.
// Build with +define+TLM_WATCHDOG_EN to expect the stuck-controller fault.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       flt;
        logic [2:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b1;
    logic       ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b1;
    logic       ns_g_o, ns_y_o, ns_r_o;
    logic       ew_g_o, ew_y_o, ew_r_o;
    logic       fault;
    logic [2:0] fault_code;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    traffic_conflict_monitor #(
        .MIN_YELLOW_TICKS(2),
        .WATCHDOG_TICKS  (16),
        .FLASH_HALF_TICKS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .ns_g      (ns_g),
        .ns_y      (ns_y),
        .ns_r      (ns_r),
        .ew_g      (ew_g),
        .ew_y      (ew_y),
        .ew_r      (ew_r),
        .ns_g_o    (ns_g_o),
        .ns_y_o    (ns_y_o),
        .ns_r_o    (ns_r_o),
        .ew_g_o    (ew_g_o),
        .ew_y_o    (ew_y_o),
        .ew_r_o    (ew_r_o),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the output expected after the next rising edge
    task automatic drive(input logic r, input logic [2:0] ns, input logic [2:0] ew,
                         input logic tk, input logic [2:0] ens, input logic [2:0] eew,
                         input logic ef, input logic [2:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        rst  = r;
        tick = tk;
        {ns_g, ns_y, ns_r} = ns;
        {ew_g, ew_y, ew_r} = ew;
        e.ns = ens; e.ew = eew; e.flt = ef; e.code = ec;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic pass(input logic [2:0] ns, input logic [2:0] ew, input logic tk, input string nm);
        drive(1'b0, ns, ew, tk, ns, ew, 1'b0, 3'd0, nm);
    endtask

    task automatic flt(input logic [2:0] ns, input logic [2:0] ew, input logic tk,
                       input logic red, input logic [2:0] code, input string nm);
        drive(1'b0, ns, ew, tk, {2'b00, red}, {2'b00, red}, 1'b1, code, nm);
    endtask

    task automatic do_reset(input string nm);
        drive(1'b1, R, R, 1'b0, R, R, 1'b0, 3'd0, nm);
    endtask

    // Controller phase held for nticks ticks, tick every 4 clocks, never on a change
    task automatic run_phase(input logic [2:0] ns, input logic [2:0] ew, input int nticks, input string nm);
        for (int i = 0; i < 4 * nticks; i++) begin
            pass(ns, ew, (i % 4) == 3, nm);
        end
    endtask

    task automatic legal_cycle(input string nm);
        run_phase(G, R, 5, nm);
        run_phase(Y, R, 2, nm);
        run_phase(R, G, 5, nm);
        run_phase(R, Y, 2, nm);
    endtask

    // Monitor: one comparison per cycle shortly after the rising edge
    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act.ns   = {ns_g_o, ns_y_o, ns_r_o};
                act.ew   = {ew_g_o, ew_y_o, ew_r_o};
                act.flt  = fault;
                act.code = fault_code;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got ns=%b ew=%b fault=%b code=%0d, want ns=%b ew=%b fault=%b code=%0d",
                             nm, act.ns, act.ew, act.flt, act.code, e.ns, e.ew, e.flt, e.code);
                end
            end
        end
    end

    initial begin
        // Reset state and a legal three-cycle run
        do_reset("reset_state");
        for (int c = 0; c < 3; c++) legal_cycle("legal_cycle");

        // Conflict, then fail-safe flashing with inputs ignored
        do_reset("reset");
        pass(G, R, 1'b0, "pre_conflict");
        flt(G, G, 1'b0, 1'b1, 3'd2, "conflict");
        flt(G, R, 1'b0, 1'b1, 3'd2, "flash_hold_1");
        flt(Y, G, 1'b1, 1'b0, 3'd2, "flash_tick_0");
        flt(G, R, 1'b0, 1'b0, 3'd2, "flash_hold_0");
        flt(R, R, 1'b1, 1'b1, 3'd2, "flash_tick_1");

        // Reset while in FAULT, then a legal cycle
        do_reset("reset_mid_fault");
        legal_cycle("post_reset_cycle");

        // Skip yellow G->R, flash 1,0,1 on successive ticks
        do_reset("reset");
        pass(G, R, 1'b0, "pre_skip");
        flt(R, R, 1'b0, 1'b1, 3'd3, "skip_yellow");
        flt(R, R, 1'b0, 1'b1, 3'd3, "skip_flash_a");
        flt(R, R, 1'b1, 1'b0, 3'd3, "skip_flash_b");
        flt(R, R, 1'b0, 1'b0, 3'd3, "skip_flash_c");
        flt(R, R, 1'b1, 1'b1, 3'd3, "skip_flash_d");

        // Short yellow: one tick of Y before R
        do_reset("reset");
        pass(G, R, 1'b0, "sy_green");
        pass(Y, R, 1'b0, "sy_enter");
        pass(Y, R, 1'b1, "sy_tick1");
        pass(Y, R, 1'b0, "sy_wait");
        flt(R, R, 1'b0, 1'b1, 3'd4, "short_yellow");

        // Same sequence with two ticks is legal
        do_reset("reset");
        pass(G, R, 1'b0, "ly_green");
        pass(Y, R, 1'b0, "ly_enter");
        pass(Y, R, 1'b1, "ly_tick1");
        pass(Y, R, 1'b0, "ly_wait");
        pass(Y, R, 1'b1, "ly_tick2");
        pass(Y, R, 1'b0, "ly_wait2");
        pass(R, R, 1'b0, "yellow_ok");
        pass(R, G, 1'b0, "ly_ew_green");

        // Priority: not-one-hot beats conflict and sequence
        do_reset("reset");
        pass(G, R, 1'b0, "pre_hot");
        flt(3'b101, G, 1'b0, 1'b1, 3'd1, "not_one_hot");

        // Dark lamp is not one-hot
        do_reset("reset");
        pass(G, R, 1'b0, "pre_dark");
        flt(3'b000, R, 1'b0, 1'b1, 3'd1, "dark_lamp");

        // Conflict beats illegal sequence (EW R->Y while NS green)
        do_reset("reset");
        pass(G, R, 1'b0, "pre_prio");
        flt(G, Y, 1'b0, 1'b1, 3'd2, "conflict_over_seq");

        // Frozen inputs: 16 ticks after the last change
        do_reset("reset");
        pass(G, R, 1'b0, "wd_start");
        for (int i = 0; i < 64; i++) pass(G, R, (i % 4) == 3, "wd_hold");
`ifdef TLM_WATCHDOG_EN
        flt(G, R, 1'b0, 1'b1, 3'd5, "watchdog");
`else
        for (int i = 0; i < 24; i++) pass(G, R, (i % 4) == 3, "no_watchdog");
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
